// File: rtl/writeback_register_file_pkg.sv
// Shared pipeline definitions for the MEM/WB barrier, the control decoder and
// the writeback stage: architectural widths, the zero register index and the
// writeback-source encoding.
package writeback_register_file_pkg;

    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

    // Which pipeline result is committed at writeback.
    typedef enum logic {
        WB_SRC_EXEC = 1'b0,
        WB_SRC_MEM  = 1'b1
    } wbSource_e;

endpackage

// File: rtl/writeback_register_file_if.sv
// MEM/WB and ID-read bundle for the writeback register file. The master side
// is the pipeline (MEM/WB barrier and ID stage); the slave side is the
// register file itself.
interface writeback_register_file_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 32
);

    logic [DATA_WIDTH-1:0]  wbMemoryData;
    logic [DATA_WIDTH-1:0]  wbExecutionData;
    logic                   wbShouldUseMemoryData;
    logic                   wbIsRegisterWrite;
    logic [ADDR_WIDTH-1:0]  wbRegisterDestination;
    logic [ADDR_WIDTH-1:0]  idReadAddress1;
    logic [ADDR_WIDTH-1:0]  idReadAddress2;
    logic [DATA_WIDTH-1:0]  idReadData1;
    logic [DATA_WIDTH-1:0]  idReadData2;
    logic [DATA_WIDTH-1:0]  wbWriteBackData;
    logic [COUNT_WIDTH-1:0] writeCount;

    modport master (
        output wbMemoryData,
        output wbExecutionData,
        output wbShouldUseMemoryData,
        output wbIsRegisterWrite,
        output wbRegisterDestination,
        output idReadAddress1,
        output idReadAddress2,
        input  idReadData1,
        input  idReadData2,
        input  wbWriteBackData,
        input  writeCount
    );

    modport slave (
        input  wbMemoryData,
        input  wbExecutionData,
        input  wbShouldUseMemoryData,
        input  wbIsRegisterWrite,
        input  wbRegisterDestination,
        input  idReadAddress1,
        input  idReadAddress2,
        output idReadData1,
        output idReadData2,
        output wbWriteBackData,
        output writeCount
    );

endinterface

// File: rtl/writeback_register_file_select.sv
// Writeback source mux: picks the load data or the execution result. Kept as
// its own block so the EX forwarding path can reuse the identical selection.
module writeback_select
    import writeback_register_file_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN
) (
    input  wbSource_e             source,
    input  logic [DATA_WIDTH-1:0] execData,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic [DATA_WIDTH-1:0] result
);

    // Load data only when the instruction asked for it, otherwise the ALU result.
    always_comb begin
        result = execData;
        if (source == WB_SRC_MEM) begin
            result = memData;
        end
    end

endmodule

// File: rtl/writeback_register_file.sv
// Writeback stage and integer register file. Commits the selected writeback
// value, serves two combinational ID read ports with write-first bypass, keeps
// x0 at zero and counts retired register writes.
module writeback_register_file
    import writeback_register_file_pkg::*;
#(
    parameter int DATA_WIDTH  = XLEN,
    parameter int REG_COUNT   = 32,
    parameter int ADDR_WIDTH  = REG_ADDR_WIDTH,
    parameter int COUNT_WIDTH = 32
) (
    input logic                      clk,
    input logic                      resetN,
    writeback_register_file_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_INDEX = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0]  regFile [REG_COUNT];
    logic [DATA_WIDTH-1:0]  writeBackData;
    logic [DATA_WIDTH-1:0]  readData1;
    logic [DATA_WIDTH-1:0]  readData2;
    logic [COUNT_WIDTH-1:0] writeCounter;
    logic                   writeEnable;
    logic                   bypassEnable;

    writeback_select #(
        .DATA_WIDTH (DATA_WIDTH)
    ) selectUnit (
        .source   (wbSource_e'(bus.wbShouldUseMemoryData)),
        .execData (bus.wbExecutionData),
        .memData  (bus.wbMemoryData),
        .result   (writeBackData)
    );

    // Writes to x0 are dropped here so they neither store nor count; the
    // bypass is also held off during reset so reads stay at zero.
    always_comb begin
        writeEnable  = bus.wbIsRegisterWrite && (bus.wbRegisterDestination != ZERO_INDEX);
        bypassEnable = writeEnable && resetN;
    end

    // Register array: cleared asynchronously, one commit per edge, x0 untouched.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regFile[i] <= '0;
            end
        end else if (writeEnable) begin
            regFile[bus.wbRegisterDestination] <= writeBackData;
        end
    end

    // Retired-write counter, free-running wrap at the top of its range.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            writeCounter <= '0;
        end else if (writeEnable) begin
            writeCounter <= writeCounter + COUNT_WIDTH'(1);
        end
    end

    // Read port 1: array read, overridden by the in-flight write, x0 forced to zero.
    always_comb begin
        readData1 = regFile[bus.idReadAddress1];
        if (bypassEnable && (bus.idReadAddress1 == bus.wbRegisterDestination)) begin
            readData1 = writeBackData;
        end
        if (bus.idReadAddress1 == ZERO_INDEX) begin
            readData1 = '0;
        end
    end

    // Read port 2: same rules as port 1, fully independent of it.
    always_comb begin
        readData2 = regFile[bus.idReadAddress2];
        if (bypassEnable && (bus.idReadAddress2 == bus.wbRegisterDestination)) begin
            readData2 = writeBackData;
        end
        if (bus.idReadAddress2 == ZERO_INDEX) begin
            readData2 = '0;
        end
    end

    // Drive the bundle outputs.
    always_comb begin
        bus.idReadData1     = readData1;
        bus.idReadData2     = readData2;
        bus.wbWriteBackData = writeBackData;
        bus.writeCount      = writeCounter;
    end

endmodule

// File: doc/writeback_register_file.md
Name: writeback_register_file

Overview:
- Receiving end of the MEM/WB pipeline interface.
- Consumes the WB-stage signals and selects the writeback value (memory data vs execution result).
- Commits that value into the 32-entry integer register file, which the ID stage reads through two read ports.
- Provides write-first bypass so ID sees a value in the same cycle WB commits it, and keeps a retired-write counter for debug and performance.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports
- REG_COUNT, 32, number of architectural registers; entry 0 is hardwired zero
- ADDR_WIDTH, 5, register index width; must equal clog2(REG_COUNT)
- COUNT_WIDTH, 32, width of the writeCount counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- resetN  in  1  asynchronous, active-low reset
- wbMemoryData  in  DATA_WIDTH  load data from the MEM/WB barrier
- wbExecutionData  in  DATA_WIDTH  ALU/execution result from the MEM/WB barrier
- wbShouldUseMemoryData  in  1  1 selects wbMemoryData, 0 selects wbExecutionData
- wbIsRegisterWrite  in  1  instruction in WB writes a register
- wbRegisterDestination  in  ADDR_WIDTH  destination register index
- idReadAddress1  in  ADDR_WIDTH  ID read port 1 index
- idReadAddress2  in  ADDR_WIDTH  ID read port 2 index
- idReadData1  out  DATA_WIDTH  read port 1 data (combinational)
- idReadData2  out  DATA_WIDTH  read port 2 data (combinational)
- wbWriteBackData  out  DATA_WIDTH  selected writeback value, for EX forwarding
- writeCount  out  COUNT_WIDTH  number of committed register writes since reset

Behaviour:
- Reset: resetN low asynchronously clears all REG_COUNT entries and writeCount to 0.
  - While resetN is low, no write or count occurs. idReadData1/2 read 0.
  - The first possible write is at the first rising edge after resetN goes high.
- Writeback select (combinational): wbWriteBackData = wbShouldUseMemoryData ? wbMemoryData : wbExecutionData.
  - Valid regardless of wbIsRegisterWrite.
- Effective write: writeEnable = wbIsRegisterWrite AND (wbRegisterDestination != 0).
  - On a rising edge with writeEnable, entry[wbRegisterDestination] <= wbWriteBackData. Latency is 1 edge.
- Register 0: never written. Reads of index 0 always return 0, including during bypass.
- Read ports are combinational, asynchronous reads of the register array. Both ports are independent and may use the same index.
- Write-first bypass: if writeEnable and idReadAddressN == wbRegisterDestination, then idReadDataN = wbWriteBackData in the same cycle, before the edge commits it.
  - Applies to each port independently, and to both ports at once when both hit.
- writeCount increments by 1 on each rising edge with writeEnable.
  - Wraps from 2^COUNT_WIDTH-1 to 0 without flagging.
  - A write to x0 (suppressed) does not count.
- Back-to-back writes to the same register on consecutive edges: the last one wins. No stall, no backpressure; the block accepts one write every cycle.
- X/undefined inputs on the wb* data buses are don't-care when wbIsRegisterWrite=0. They must not corrupt stored state.

Decomposition:
- Shared pipeline package holds:
  - REG_ADDR_WIDTH=5, XLEN=32, ZERO_REG=5'd0
  - the writeback-source encoding (WB_SRC_EXEC=0, WB_SRC_MEM=1), shared with the MEM/WB barrier and control decoder
- One natural sub-module: writeback_select, the 2:1 data mux producing wbWriteBackData.
  - Reused by the EX forwarding path.
- Register array, bypass and counter stay in this module.

Test Plan:
- Reset: hold resetN=0, drive write of 0xDEADBEEF to x5 with enable=1, release -> idReadData1 at x5 = 0, writeCount = 0; assert resetN=0 mid-run after writes -> x5 reads 0 immediately, without waiting for a clock edge.
- Source select: write x3 with exec=0x11111111, mem=0x22222222, useMem=1 -> x3 = 0x22222222; then useMem=0 to x4 -> x4 = 0x11111111; writeCount = 2.
- x0 protection: write 0xFFFFFFFF to x0 with enable=1 -> reads of x0 = 0, writeCount unchanged; enable=0 to x7 -> x7 unchanged.
- Bypass: x9 holds 0xA, same cycle write 0xB to x9 with both read addresses = 9 -> both reads = 0xB before the edge and 0xB after; read x10 in same cycle -> its stored value.
- Back-to-back: consecutive edges write x12=1, 2, 3 -> x12 = 3, writeCount += 3; then the full 31-register sweep with data = index*0x01010101 reads back exactly.
- Counter wrap: force writeCount to 0xFFFFFFFF (or COUNT_WIDTH=4, 16 writes) -> next effective write gives 0.
